conv_enc_framer: RTL and testbench

Rate-1/2 convolutional encoder with zero-tail frame termination. It generates the coded symbol stream that the Viterbi decoder (BMU/ACS/TBU chain) consumes. After every frame it appends K-1 zero tail bits, so the encoder state returns to 0. The decoder's traceback can therefore start from InitState = 0. It sits on the transmit/stimulus side and drives symbols into the decoder input or a channel model.

---
 rtl/conv_enc_framer_pkg.sv | 26 ++
 rtl/conv_enc_framer_if.sv | 25 ++
 rtl/conv_enc_framer_core.sv | 20 ++
 rtl/conv_enc_framer.sv | 118 +++++++++++
 tb/tb_conv_enc_framer.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_enc_framer_pkg.sv
// Shared constants and types for the rate-1/2 zero-tail convolutional encoder.
// The code constants are the ones the Viterbi decoder and traceback unit are built against.
package conv_enc_framer_pkg;

  localparam int               K_DEF    = 9;
  localparam int               WD_STATE = K_DEF - 1;
  localparam logic [K_DEF-1:0] G0_DEF   = 9'o561;
  localparam logic [K_DEF-1:0] G1_DEF   = 9'o753;

  typedef enum logic {
    ST_DATA,
    ST_TAIL
  } enc_state_e;

  typedef struct packed {
    logic [1:0] sym;
    logic       first;
    logic       last;
  } sym_word_t;

  // Even parity of a tap-masked shift-register word.
  function automatic logic parity(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/conv_enc_framer_if.sv
// Bit-in / symbol-out stream bundle of the encoder framer.
// The framer is the slave; the bit source and the symbol sink form the master side.
interface conv_enc_framer_if;

  logic       InValid;
  logic       InReady;
  logic       InBit;
  logic       InLast;
  logic       SymValid;
  logic       SymReady;
  logic [1:0] Sym;
  logic       SymFirst;
  logic       SymLast;

  modport master (
    output InValid, InBit, InLast, SymReady,
    input  InReady, SymValid, Sym, SymFirst, SymLast
  );

  modport slave (
    input  InValid, InBit, InLast, SymReady,
    output InReady, SymValid, Sym, SymFirst, SymLast
  );

endinterface

// File: rtl/conv_enc_framer_core.sv
// Combinational rate-1/2 symbol computation from the current bit and the shift register.
// Generator bit K-1 taps the current input, bit 0 taps the oldest stored bit.
module conv_enc_framer_core
  import conv_enc_framer_pkg::*;
#(
  parameter int           K  = K_DEF,
  parameter logic [K-1:0] G0 = G0_DEF,
  parameter logic [K-1:0] G1 = G1_DEF
) (
  input  logic         b,
  input  logic [K-2:0] s,
  output logic [1:0]   sym
);

  logic [K-1:0] v;

  assign v   = {b, s};
  assign sym = {parity(32'(v & G1)), parity(32'(v & G0))};

endmodule

// File: rtl/conv_enc_framer.sv
// Convolutional encoder framer: encodes a frame of data bits, then appends K-1 zero
// tail bits so the encoder ends every frame in state 0, behind one output register stage.
module conv_enc_framer
  import conv_enc_framer_pkg::*;
#(
  parameter int           K  = K_DEF,
  parameter logic [K-1:0] G0 = G0_DEF,
  parameter logic [K-1:0] G1 = G1_DEF
) (
  input  logic                  CLOCK,
  input  logic                  Reset,
  conv_enc_framer_if.slave      bus,
  output logic [K-2:0]          EncState
);

  localparam int                 WD_TAIL   = (K > 2) ? $clog2(K - 1) : 1;
  localparam logic [WD_TAIL-1:0] TAIL_LAST = WD_TAIL'(K - 2);

  enc_state_e         state;
  enc_state_e         state_nxt;
  logic [K-2:0]       shift_reg;
  logic [WD_TAIL-1:0] tail_cnt;
  logic               first_pending;
  sym_word_t          out_reg;
  logic               sym_valid;

  logic               slot_free;
  logic               in_ready;
  logic               accept;
  logic               tail_step;
  logic               tail_done;
  logic               produce;
  logic               enc_bit;
  logic [1:0]         sym_new;

  // State register
  always_ff @(posedge CLOCK) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
    if (Reset) state <= ST_DATA;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    // NOTE: the default assignment first covers every path, so no latch is inferred.
    state_nxt = state;
    unique case (state)
      ST_DATA: if (accept && bus.InLast) state_nxt = ST_TAIL;
      ST_TAIL: if (tail_done)            state_nxt = ST_DATA;
    endcase
  end

  // Output / control decode: a slot is free when the output register is empty or draining.
  always_comb begin
    slot_free = !sym_valid || bus.SymReady;
    in_ready  = 1'b0;
    tail_step = 1'b0;
    enc_bit   = 1'b0;
    unique case (state)
      ST_DATA: begin
        in_ready = slot_free;
        enc_bit  = bus.InBit;
      end
      ST_TAIL: tail_step = slot_free;
    endcase
    accept    = bus.InValid && in_ready;
    tail_done = tail_step && (tail_cnt == TAIL_LAST);
    produce   = accept || tail_step;
  end

  conv_enc_framer_core #(
    .K  (K),
    .G0 (G0),
    .G1 (G1)
  ) u_core (
    .b   (enc_bit),
    .s   (shift_reg),
    .sym (sym_new)
  );

  // Encoder shift register, tail counter and frame-start tracking
  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      shift_reg     <= '0;
      tail_cnt      <= '0;
      first_pending <= 1'b1;
    end else begin
      if (produce) shift_reg <= {enc_bit, shift_reg[K-2:1]};

      if (accept && bus.InLast) tail_cnt <= '0;
      else if (tail_step)       tail_cnt <= tail_done ? '0 : tail_cnt + 1'b1;

      if (tail_done)   first_pending <= 1'b1;
      else if (accept) first_pending <= 1'b0;
    end
  end

  // Output register: loads on a new symbol, holds under backpressure, empties on a bare handshake.
  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      out_reg   <= '0;
      sym_valid <= 1'b0;
    end else if (produce) begin
      out_reg   <= '{sym: sym_new, first: first_pending, last: tail_done};
      sym_valid <= 1'b1;
    end else if (bus.SymReady) begin
      sym_valid <= 1'b0;
    end
  end

  assign bus.InReady  = in_ready;
  assign bus.SymValid = sym_valid;
  assign bus.Sym      = out_reg.sym;
  assign bus.SymFirst = out_reg.first;
  assign bus.SymLast  = out_reg.last;
  assign EncState     = shift_reg;

endmodule

// File: tb/tb_conv_enc_framer.sv
// Self-checking bench for conv_enc_framer: directed frame scenarios plus random traffic,
// scored against a convolution model computed straight from the generator polynomials.
module tb_conv_enc_framer;

  localparam int           K  = 9;
  localparam logic [K-1:0] G0 = 9'o561;
  localparam logic [K-1:0] G1 = 9'o753;
  localparam logic [1:0]   IMP [9] = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b01,
                                       2'b10, 2'b00, 2'b10, 2'b11};

  logic         CLOCK = 1'b0;
  logic         Reset;
  logic [K-2:0] EncState;

  conv_enc_framer_if bus ();

  conv_enc_framer #(.K(K), .G0(G0), .G1(G1)) dut (
    .CLOCK    (CLOCK),
    .Reset    (Reset),
    .bus      (bus.slave),
    .EncState (EncState)
  );

  always #5 CLOCK = ~CLOCK;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [3:0]   exp_q [$];   // {first, last, sym[1:0]}
  logic         hist [$];    // bits of the frame being encoded, including tail zeros
  logic [1:0]   got_sym [$];
  logic         got_first [$];
  logic         got_last [$];
  int           got_cyc [$];
  int           cyc = 0;
  logic         last_acc;
  logic         last_in_ready;
  logic         hold_valid = 1'b0;
  logic [1:0]   hold_sym;
  logic [K-2:0] hold_state;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Symbol t of a frame is the mod-2 convolution of the frame bits with each generator.
  task automatic push_expected(input logic is_last);
    int   t  = hist.size() - 1;
    logic s0 = 1'b0;
    logic s1 = 1'b0;
    for (int i = 0; i < K; i++) begin
      if (t - i >= 0 && hist[t - i]) begin
        s0 ^= G0[K-1-i];
        s1 ^= G1[K-1-i];
      end
    end
    exp_q.push_back({t == 0, is_last, s1, s0});
  endtask

  task automatic model_accept(input logic b, input logic l);
    hist.push_back(b);
    push_expected(1'b0);
    if (l) begin
      for (int j = 1; j < K; j++) begin
        hist.push_back(1'b0);
        push_expected(j == K - 1);
      end
      hist.delete();
    end
  endtask

  task automatic clear_got();
    got_sym.delete();
    got_first.delete();
    got_last.delete();
    got_cyc.delete();
  endtask

  // One clock cycle: drive at the falling edge, observe 1 time unit later, score the
  // handshakes that the next rising edge will complete.
  task automatic cycle(input logic rst, input logic v, input logic b, input logic l, input logic r);
    logic [3:0] e;
    @(negedge CLOCK);
    Reset        = rst;
    bus.InValid  = v;
    bus.InBit    = b;
    bus.InLast   = l;
    bus.SymReady = r;
    #1;
    last_acc      = 1'b0;
    last_in_ready = bus.InReady;
    if (rst) begin
      exp_q.delete();
      hist.delete();
      hold_valid = 1'b0;
    end else begin
      if (hold_valid) begin
        check("hold_sym", bus.Sym, hold_sym);
        check("hold_valid", bus.SymValid, 1);
        check("hold_state", EncState, hold_state);
      end
      if (bus.SymValid && !bus.SymReady) check("bp_inready", bus.InReady, 0);
      if (bus.SymValid && bus.SymReady) begin
        if (exp_q.size() == 0) begin
          check("unexpected_sym", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("sym", bus.Sym, e[1:0]);
          check("sym_first", bus.SymFirst, e[3]);
          check("sym_last", bus.SymLast, e[2]);
        end
        got_sym.push_back(bus.Sym);
        got_first.push_back(bus.SymFirst);
        got_last.push_back(bus.SymLast);
        got_cyc.push_back(cyc);
      end
      if (bus.InValid && bus.InReady) begin
        last_acc = 1'b1;
        model_accept(b, l);
      end
      hold_valid = bus.SymValid && !bus.SymReady;
      hold_sym   = bus.Sym;
      hold_state = EncState;
    end
    cyc++;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge CLOCK);
    Reset        = 1'b0;
    bus.InValid  = 1'b0;
    bus.InBit    = 1'b0;
    bus.InLast   = 1'b0;
    bus.SymReady = 1'b1;
    #1;
    cyc++;
    check("rst_sym_valid", bus.SymValid, 0);
    check("rst_sym", bus.Sym, 0);
    check("rst_sym_first", bus.SymFirst, 0);
    check("rst_sym_last", bus.SymLast, 0);
    check("rst_enc_state", EncState, 0);
    check("rst_in_ready", bus.InReady, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (exp_q.size() != 0 || bus.SymValid); i++)
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Single-bit frame; mode 1 applies the 1,0,0,1 SymReady pattern.
  task automatic run_impulse(input int mode);
    logic sent = 1'b0;
    logic r;
    clear_got();
    for (int c = 0; c < 100 && got_sym.size() < 9; c++) begin
      r = (mode == 0) || (c % 4 == 0) || (c % 4 == 3);
      cycle(1'b0, !sent, 1'b1, 1'b1, r);
      if (last_acc) sent = 1'b1;
    end
    check("imp_count", got_sym.size(), 9);
    for (int i = 0; i < got_sym.size() && i < 9; i++) begin
      check($sformatf("imp_sym%0d", i), got_sym[i], IMP[i]);
      check($sformatf("imp_first%0d", i), got_first[i], i == 0);
      check($sformatf("imp_last%0d", i), got_last[i], i == 8);
    end
    check("imp_end_state", EncState, 0);
    drain();
  endtask

  task automatic run_random(input int n_frames);
    int   frame  = 0;
    int   idx    = 0;
    int   len    = $urandom_range(1, 10);
    logic b      = 1'($urandom);
    logic v;
    logic r;
    for (int budget = 0; budget < 5000 && frame < n_frames; budget++) begin
      v = ($urandom % 4) != 0;
      r = ($urandom % 10) < 7;
      cycle(1'b0, v, b, idx == len - 1, r);
      if (last_acc) begin
        idx++;
        b = 1'($urandom);
        if (idx == len) begin
          frame++;
          idx = 0;
          len = $urandom_range(1, 10);
        end
      end
    end
    check("rand_frames", frame, n_frames);
    drain();
    check("rand_end_state", EncState, 0);
  endtask

  initial begin
    int sent;
    int low;
    Reset        = 1'b1;
    bus.InValid  = 1'b0;
    bus.InBit    = 1'b0;
    bus.InLast   = 1'b0;
    bus.SymReady = 1'b1;
    do_reset(2);

    run_impulse(0);

    // All-ones 4-bit frame and the tail-length InReady gap
    clear_got();
    sent = 0;
    for (int c = 0; c < 50 && sent < 4; c++) begin
      cycle(1'b0, 1'b1, 1'b1, sent == 3, 1'b1);
      if (last_acc) sent++;
    end
    check("ones_sent", sent, 4);
    low = 0;
    for (int c = 0; c < 50; c++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (last_in_ready) break;
      low++;
    end
    check("ones_inready_low", low, 8);
    drain();
    check("ones_count", got_sym.size(), 12);
    check("ones_end_state", EncState, 0);

    run_impulse(1);

    // Back-to-back impulse frames with InValid held high
    clear_got();
    sent = 0;
    for (int c = 0; c < 100 && got_sym.size() < 18; c++) begin
      cycle(1'b0, sent < 2, 1'b1, 1'b1, 1'b1);
      if (last_acc) sent++;
    end
    check("b2b_count", got_sym.size(), 18);
    if (got_sym.size() == 18) begin
      check("b2b_span", got_cyc[17] - got_cyc[0], 17);
      check("b2b_last8", got_last[8], 1);
      check("b2b_first9", got_first[9], 1);
      for (int i = 0; i < 18; i++) check($sformatf("b2b_sym%0d", i), got_sym[i], IMP[i % 9]);
    end
    drain();

    // Reset while the tail counter is at 3, then a clean impulse frame
    clear_got();
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("rt_accept", last_acc, 1);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rt_in_tail", last_in_ready, 0);
    do_reset(1);
    run_impulse(0);

    run_random(30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
